// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   Burst reader for the external configuration flash. After a power-up wait
//   it accepts a start request, issues a read command plus a 24-bit address
//   over SPI mode 0 (flashClk = clk/2), and shifts BYTE_COUNT bytes into a
//   local buffer. The text engine reads the buffer through a registered
//   character port.
//
//   Optional feature macro: FLASH_FAST_READ_EN
//     defined   -> command 8'h0B plus 8 dummy flashClk periods before data
//     undefined -> command 8'h03, data follows the address directly
//
// Ports
//   clk, reset         system clock, asynchronous active-high reset
//   start/readAddress  burst request (honoured only in IDLE) and first address
//   busy/done          burst in flight / one-cycle completion pulse
//   flashClk/Mosi/Cs   SPI outputs (Cs active low), flashMiso SPI input
//   charAddress        buffer read index, charOutput = byte one cycle later
module spi_flash_reader #(
    parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
    parameter int unsigned BYTE_COUNT   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] readAddress,
    output logic        busy,
    output logic        done,
    output logic        flashClk,
    input  logic        flashMiso,
    output logic        flashMosi,
    output logic        flashCs,
    input  logic [5:0]  charAddress,
    output logic [7:0]  charOutput
);

    localparam logic [5:0] LAST_BYTE = 6'(BYTE_COUNT - 1);
    localparam logic [6:0] BUF_DEPTH = 7'(BYTE_COUNT);
    localparam logic [7:0] BLANK     = 8'h20;
`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] READ_CMD  = 8'h0B;
`else
    localparam logic [7:0] READ_CMD  = 8'h03;
`endif

    typedef enum logic [2:0] {INIT_WAIT, IDLE, SEND, DUMMY, READ, DONE} state_t;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [23:0] addr;
    } flashCmd_t;

    state_t      state, nextState;
    logic [31:0] waitCnt;
    logic [31:0] shiftReg;
    logic [4:0]  bitCnt;
    logic        phase;
    logic [6:0]  byteReg;
    logic [5:0]  byteIndex;
    logic [7:0]  buffer [64];
    logic        active;
    flashCmd_t   cmdWord;

    always_comb begin
        cmdWord.cmd  = READ_CMD;
        cmdWord.addr = readAddress;
    end

    // Chip select and SPI clock are pure decodes of registered state, so an
    // asynchronous reset releases the bus in the same instant.
    assign active    = (state == SEND) || (state == DUMMY) || (state == READ);
    assign busy      = active;
    assign done      = (state == DONE);
    assign flashCs   = ~active;
    assign flashClk  = active & phase;
    assign flashMosi = (state == SEND) & shiftReg[31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT_WAIT;
        else       state <= nextState;
    end

    // phase=1 is the high half of a bit; the edge ending it is the bit end.
    always_comb begin
        nextState = state;
        case (state)
            INIT_WAIT: if (waitCnt + 32'd1 >= STARTUP_WAIT) nextState = IDLE;
            IDLE:      if (start) nextState = SEND;
            SEND: begin
                if (phase && bitCnt == 5'd31) begin
`ifdef FLASH_FAST_READ_EN
                    nextState = DUMMY;
`else
                    nextState = READ;
`endif
                end
            end
            DUMMY:     if (phase && bitCnt[2:0] == 3'd7) nextState = READ;
            READ: begin
                if (phase && bitCnt[2:0] == 3'd7 && byteIndex == LAST_BYTE)
                    nextState = DONE;
            end
            DONE:      nextState = IDLE;
            default:   nextState = INIT_WAIT;
        endcase
    end

    // bitCnt is 5 bits: it wraps to 0 after the 32 command/address bits, and
    // only its low 3 bits matter in DUMMY and READ, so it never needs clearing
    // between phases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt   <= '0;
            shiftReg  <= '0;
            bitCnt    <= '0;
            phase     <= 1'b0;
            byteReg   <= '0;
            byteIndex <= '0;
            for (int i = 0; i < 64; i++) buffer[i] <= BLANK;
        end else begin
            if (state == INIT_WAIT) waitCnt <= waitCnt + 32'd1;

            if (state == IDLE && start) begin
                shiftReg  <= cmdWord;
                bitCnt    <= '0;
                phase     <= 1'b0;
                byteIndex <= '0;
            end else if (active) begin
                phase <= ~phase;
                if (phase) begin
                    bitCnt <= bitCnt + 5'd1;
                    if (state == SEND) shiftReg <= {shiftReg[30:0], 1'b0};
                    if (state == READ) begin
                        byteReg <= {byteReg[5:0], flashMiso};
                        if (bitCnt[2:0] == 3'd7) begin
                            buffer[byteIndex] <= {byteReg, flashMiso};
                            byteIndex         <= byteIndex + 6'd1;
                        end
                    end
                end
            end
        end
    end

    // Registered read port; a write landing on the same edge is not
    // forwarded, so the old byte is returned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            charOutput <= BLANK;
        else if ({1'b0, charAddress} < BUF_DEPTH)
            charOutput <= buffer[charAddress];
        else
            charOutput <= BLANK;
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: a behavioural SPI flash responder,
// a scoreboard of expected headers/bursts/reads, and a monitor that compares
// whenever the DUT presents an output.
module tb_spi_flash_reader;

    localparam int          BC = 32;
    localparam logic [31:0] SW = 32'd16;
`ifdef FLASH_FAST_READ_EN
    localparam int          HDR = 40;
    localparam logic [7:0]  CMD = 8'h0B;
`else
    localparam int          HDR = 32;
    localparam logic [7:0]  CMD = 8'h03;
`endif
    localparam int BURST = 2 * HDR + 16 * BC;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] readAddress;
    logic        busy, done, flashClk, flashMosi, flashCs;
    logic        flashMiso;
    logic [5:0]  charAddress;
    logic [7:0]  charOutput;

    spi_flash_reader #(.STARTUP_WAIT(SW), .BYTE_COUNT(BC)) dut (
        .clk(clk), .reset(reset), .start(start), .readAddress(readAddress),
        .busy(busy), .done(done), .flashClk(flashClk), .flashMiso(flashMiso),
        .flashMosi(flashMosi), .flashCs(flashCs), .charAddress(charAddress),
        .charOutput(charOutput)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Flash contents: any address returns a byte derived from the address.
    function automatic logic [7:0] memByte(input logic [23:0] a);
        return 8'(a[7:0] + 8'h41) ^ a[15:8];
    endfunction

    typedef struct { logic [7:0] exp; int due; int idx; } rd_t;

    logic [31:0] hdrQ[$];
    logic [23:0] doneQ[$];
    rd_t         rdQ[$];
    logic [7:0]  refBuf [64];

    function automatic logic [7:0] expRead(input int idx);
        return (idx < BC) ? refBuf[idx] : 8'h20;
    endfunction

    // Flash model + monitor, all sampled mid-cycle
    int          spiBits    = 0;
    logic [31:0] spiIn      = '0;
    logic [23:0] spiAddr    = '0;
    logic        mosiSetup  = 1'b0;
    logic        prevClk    = 1'b0;
    logic        prevBusy   = 1'b0;
    bit          abortBurst = 1'b0;
    int          busyStart  = 0;

    always @(negedge clk) begin
        if (flashCs !== 1'b0) begin
            if (spiBits != 0) begin
                if (!abortBurst) check("edgeCount", spiBits, HDR + 8 * BC);
                abortBurst = 1'b0;
            end
            spiBits = 0;
        end else begin
            if (flashClk && !prevClk) begin
                if (spiBits < 32) begin
                    check("mosiStable", flashMosi, mosiSetup);
                    spiIn = {spiIn[30:0], flashMosi};
                end else begin
                    check("mosiIdle", flashMosi, 1'b0);
                end
                spiBits++;
                if (spiBits == 32) begin
                    if (hdrQ.size() == 0) check("hdrUnexpected", spiIn, 32'hFFFF_FFFF);
                    else check("header", spiIn, hdrQ.pop_front());
                    spiAddr = spiIn[23:0];
                end
            end
            if (!flashClk && prevClk && spiBits >= HDR) begin
                int d;
                logic [7:0] b;
                d = spiBits - HDR;
                b = memByte(spiAddr + 24'(d / 8));
                flashMiso = b[7 - (d % 8)];
            end
            if (!flashClk) mosiSetup = flashMosi;
        end
        prevClk = flashClk;

        if (busy && !prevBusy) busyStart = cyc;
        if (done === 1'b1) begin
            if (doneQ.size() == 0) begin
                check("doneUnexpected", 32'd1, 32'd0);
            end else begin
                logic [23:0] a;
                a = doneQ.pop_front();
                check("doneLatency", cyc - busyStart, BURST);
                check("busyAtDone", busy, 1'b0);
                for (int i = 0; i < BC; i++) refBuf[i] = memByte(a + 24'(i));
            end
        end
        prevBusy = busy;

        if (rdQ.size() != 0 && rdQ[0].due == cyc) begin
            rd_t r;
            r = rdQ.pop_front();
            check($sformatf("charOutput[%0d]", r.idx), charOutput, r.exp);
        end
    end

    // Stimulus: all tasks run from the negedge of clk
    task automatic readChar(input int idx, input logic [7:0] exp);
        rd_t r;
        charAddress = 6'(idx);
        r.exp = exp; r.due = cyc + 1; r.idx = idx;
        rdQ.push_back(r);
        @(negedge clk);
    endtask

    task automatic issueStart(input logic [23:0] a);
        start = 1'b1; readAddress = a;
        hdrQ.push_back({CMD, a});
        doneQ.push_back(a);
        @(negedge clk);
        start = 1'b0;
        check("startBusy", busy, 1'b1);
        check("startCs", flashCs, 1'b0);
    endtask

    task automatic pulseIgnored();
        start = 1'b1; readAddress = 24'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone();
        bit seen = 1'b0;
        for (int i = 0; i < BURST + 200 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) check("doneTimeout", 32'd0, 32'd1);
    endtask

    // Leaves reset at a negedge, checks the power-up wait ignores start,
    // then launches a burst at cycle 20.
    task automatic powerUp(input logic [23:0] a);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        pulseIgnored();
        repeat (9) @(negedge clk);
        check("initIgnoreBusy", busy, 1'b0);
        check("initIgnoreCs", flashCs, 1'b1);
        repeat (5) @(negedge clk);
        issueStart(a);
    endtask

    task automatic midReset();
        @(posedge clk);
        #2;
        abortBurst = (spiBits != 0);
        reset = 1'b1;
        #1;
        check("abortCs", flashCs, 1'b1);
        check("abortClk", flashClk, 1'b0);
        check("abortBusy", busy, 1'b0);
        check("abortChar", charOutput, 8'h20);
        @(negedge clk);
        hdrQ.delete(); doneQ.delete(); rdQ.delete();
        for (int i = 0; i < 64; i++) refBuf[i] = 8'h20;
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] addrA, addrB;
        for (int i = 0; i < 64; i++) refBuf[i] = 8'h20;
        reset = 1'b1; start = 1'b0; readAddress = '0; charAddress = '0; flashMiso = 1'b0;
        repeat (3) @(negedge clk);
        check("rstCs", flashCs, 1'b1);
        check("rstClk", flashClk, 1'b0);
        check("rstMosi", flashMosi, 1'b0);
        check("rstBusy", busy, 1'b0);
        check("rstDone", done, 1'b0);
        check("rstChar", charOutput, 8'h20);

        // Power-up and the reference burst at 0x100000
        powerUp(24'h100000);
        repeat (50) @(negedge clk);
        pulseIgnored();
        waitDone();
        @(negedge clk);
        readChar(0, 8'h41);
        readChar(31, 8'h60);
        readChar(40, 8'h20);

        // Back-to-back bursts: start in DONE is dropped, next cycle accepted
        addrA = 24'($urandom);
        issueStart(addrA);
        waitDone();
        addrB = 24'($urandom) ^ 24'h5A5A5A;
        start = 1'b1; readAddress = addrB;
        @(negedge clk);
        check("startInDone", busy, 1'b0);
        issueStart(addrB);
        repeat (199) @(negedge clk);
        pulseIgnored();
        readChar(2, memByte(addrB + 24'd2));
        readChar(30, memByte(addrA + 24'd30));
        waitDone();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            int idx = int'($urandom_range(0, 63));
            readChar(idx, expRead(idx));
        end

        // Reset in the middle of the eleventh data byte
        issueStart(24'($urandom));
        repeat (64 + 16 * 10 + 6) @(negedge clk);
        midReset();
        for (int i = 0; i < BC; i += 3) readChar(i, 8'h20);
        readChar(63, 8'h20);
        powerUp(24'hFFFFF8);
        waitDone();
        @(negedge clk);
        readChar(7, memByte(24'hFFFFFF));
        readChar(8, memByte(24'h000000));

        // Randomised bursts and reads
        for (int n = 0; n < 3; n++) begin
            repeat (int'($urandom_range(1, 5))) @(negedge clk);
            issueStart(24'($urandom));
            waitDone();
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                int idx = int'($urandom_range(0, 63));
                readChar(idx, expRead(idx));
            end
        end

        repeat (3) @(negedge clk);
        check("hdrQEmpty", hdrQ.size(), 0);
        check("doneQEmpty", doneQ.size(), 0);
        check("rdQEmpty", rdQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
SPI-flash burst reader that fetches a block of bytes from the external configuration flash into a local byte buffer. It exposes the buffer through a character-read port for the text engine, which renders the buffer on the OLED. It sits directly upstream of the text engine, on the flash pins. A navigation block drives its start/address inputs.

Parameters:
STARTUP_WAIT, 32'd10000000, clk cycles to wait after reset before the first flash access (flash power-up time).
BYTE_COUNT, 32, bytes fetched per burst and held in the buffer; legal range 1..64.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
readAddress  input  24  flash byte address of the first byte; captured on the accepted start.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when the last byte has been written to the buffer.
flashClk  output  1  SPI clock, mode 0, frequency clk/2.
flashMiso  input  1  SPI data from flash.
flashMosi  output  1  SPI data to flash, MSB first.
flashCs  output  1  SPI chip select, active low.
charAddress  input  6  buffer read index from the text engine.
charOutput  output  8  buffer byte at charAddress; registered, 1-cycle latency.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Outputs: flashCs=1, flashClk=0, flashMosi=0, busy=0, done=0, charOutput=8'h20.
  - Buffer contents: cleared to 8'h20.
  - State: INIT_WAIT, with the wait counter at 0.
  - Reset mid-burst aborts the transfer and deasserts flashCs in the same instant.
- INIT_WAIT: count clk cycles; after STARTUP_WAIT cycles -> IDLE. A start seen here is ignored.
- IDLE: flashCs=1, flashClk=0. On start=1:
  - capture {8'h03, readAddress} into a 32-bit shift register;
  - bit counter <= 0; go to SEND; busy=1 the next cycle.
- Bit timing, 2 clk cycles per bit:
  - phase 0: flashClk=0, flashMosi=current MSB;
  - phase 1: flashClk=1; flashMiso is sampled on the clk edge ending phase 1.
  - flashCs=0 from entry to SEND until leaving READ.
- SEND: shift out 32 bits (command, then address[23:16], [15:8], [7:0]). After bit 31 -> READ. flashMosi is don't-care after SEND and is driven 0.
- READ:
  - Shift flashMiso MSB-first into a byte register.
  - After every 8th bit, write the byte to buffer[byteIndex] and increment byteIndex.
  - After BYTE_COUNT bytes -> DONE.
  - Buffer entries not yet rewritten keep their previous burst's values.
- DONE, one cycle: flashCs=1, flashClk=0, done=1, busy=0 -> IDLE. A start in the DONE cycle is ignored. A start in the following IDLE cycle is accepted, so back-to-back bursts have 1 idle cycle minimum.
- start while busy or done: ignored, no queuing.
- Read port:
  - charOutput <= buffer[charAddress] if charAddress < BYTE_COUNT, else 8'h20.
  - Reads are allowed in every state; a same-cycle write to the read index returns the old byte.
- Address arithmetic: 24-bit. The flash wraps internally at its top address; the block does not check this.
- Burst length: exactly 32 + 8*BYTE_COUNT flashClk periods, i.e. 64 + 16*BYTE_COUNT clk cycles, with flashCs low.

Optional Feature:
FLASH_FAST_READ_EN:
- Defined: the command byte is 8'h0B (fast read), and a DUMMY state inserts 8 flashClk periods with flashMosi=0 between SEND and READ. Burst length grows by 16 clk cycles.
- Undefined: command 8'h03, no DUMMY state.

Test Plan:
1. Power-up (STARTUP_WAIT=16 in sim): start pulsed at cycle 5 -> ignored, flashCs stays 1; start at cycle 20 -> busy=1 on cycle 21, flashCs falls.
2. Start with readAddress=24'h100000 -> flashMosi bit sequence 0x03,0x10,0x00,0x00 MSB first; each bit stable while flashClk=1; exactly 32 rising flashClk edges before the read phase.
3. Flash model returns bytes 0x41,0x42,...; BYTE_COUNT=32 -> done pulse exactly 64+512 cycles after busy rises. charAddress=0 -> charOutput=8'h41 next cycle; charAddress=31 -> 8'h60; charAddress=40 -> 8'h20.
4. Reset asserted during READ byte 10 -> flashCs=1 and flashClk=0 immediately; all buffer entries read 8'h20; block re-waits STARTUP_WAIT before accepting start.
5. Second start during busy -> ignored; start one cycle after done -> accepted. Partially refetched buffer keeps old bytes beyond the current byteIndex.
6. With FLASH_FAST_READ_EN: command byte 0x0B followed by 8 dummy clocks; first sampled data bit occurs on flashClk edge 41; done arrives 16 cycles later than in scenario 3.
